proj_div_seq: RTL and testbench
===============================

Name: proj_div_seq

Overview:
Perspective-divide sequencer that feeds the shared 20-bit pipelined divider core in the raster front end.
- Accepts one camera-space vertex (x, y, z) per transaction.
- Scales x and y by the focal length and issues two back-to-back divides by z.
- Captures both quotients after the divider's fixed latency.
- Emits screen coordinates and a clip flag with a valid/ready handshake.

Parameters:
DIV_LAT, 24, cycles from operands on div_dividend/div_divisor to the matching result on div_quotient
FOCAL, 256, unsigned focal scale applied to x and y before division
SCR_W, 640, screen width in pixels
SCR_H, 480, screen height in pixels

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  vertex available
in_ready  out  1  block can accept a vertex
in_x  in  20  signed camera x
in_y  in  20  signed camera y
in_z  in  20  signed camera depth
div_dividend  out  20  signed dividend to divider core
div_divisor  out  20  signed divisor to divider core
div_quotient  in  20  signed quotient from divider core; truncates toward zero
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_sx  out  10  screen x, clamped to 0..SCR_W-1
out_sy  out  9  screen y, clamped to 0..SCR_H-1
out_clip  out  1  vertex is off-screen or behind the eye

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: in_ready=1, out_valid=0, out_sx=0, out_sy=0, out_clip=0, div_dividend=0, div_divisor=1, state=IDLE, lat counter=0.
- Divider contract: the core samples operands every clk and is fully pipelined. Operands driven in cycle C produce their quotient on div_quotient in cycle C+DIV_LAT.
- States:
  - IDLE: in_ready=1. On in_valid, latch x, y, z.
    - z<=0: go to HOLD with out_clip=1, out_sx=0, out_sy=0.
    - Otherwise: go to ISSUE_X.
  - ISSUE_X: div_dividend=sat(x*FOCAL), div_divisor=z. Go to ISSUE_Y.
  - ISSUE_Y: div_dividend=sat(y*FOCAL), div_divisor=z. Go to WAIT.
  - WAIT: counter runs from ISSUE_X.
    - Capture qx in the cycle ISSUE_X+DIV_LAT.
    - Capture qy in the cycle ISSUE_X+DIV_LAT+1.
    - After capturing qy, go to HOLD.
  - HOLD: out_valid=1 and outputs stable. On out_ready, go to IDLE.
- In every state other than ISSUE_X/ISSUE_Y, div_dividend=0 and div_divisor=1, so the core never sees a zero divisor.
- in_ready=1 only in IDLE. Acceptance in cycle T gives out_valid from T+DIV_LAT+3. The z<=0 path gives out_valid at T+1.
- Throughput: one vertex per DIV_LAT+4 cycles minimum. No overlap between vertices.
- Arithmetic:
  - x*FOCAL is formed at 30 bits signed, then saturated to [-524288, 524287] before issue.
  - sx = SCR_W/2 + qx; sy = SCR_H/2 - qy. Both are computed at 21 bits signed.
  - out_clip=1 if sx<0, sx>=SCR_W, sy<0 or sy>=SCR_H. Coordinates are clamped to range in that case.
- Backpressure: while HOLD and out_ready=0, all outputs hold indefinitely. Later div_quotient values are ignored.
- Reset mid-operation: all state is discarded, including divides in flight in the core. Their quotients arriving after reset are ignored, because captures happen only in WAIT.
- in_x/in_y/in_z may change freely after acceptance because they are latched.

Decomposition:
- Package proj_pkg holds:
  - the 20-bit coordinate width constant and the output widths;
  - the state enum (IDLE, ISSUE_X, ISSUE_Y, WAIT, HOLD);
  - a sat20 function for the 30-bit to 20-bit signed saturation.
- Sub-module proj_sat_mul is natural: a combinational signed 20x11 multiply with saturation, instantiated twice, or once and muxed by state.
- The clip/clamp logic stays inline.

Test Plan:
Bench settings: DIV_LAT=4, FOCAL=256, behavioural divider model with 4-cycle latency.
- Nominal: x=100, y=50, z=512 -> out_sx=370, out_sy=215, out_clip=0; out_valid exactly 7 cycles after acceptance.
- Behind eye: z=0, then z=-5 -> out_clip=1, out_sx=0, out_sy=0, out_valid 1 cycle after acceptance; div_divisor never 0 across the whole run.
- Saturation/clip: x=4000, y=0, z=1 -> dividend 524287 issued, out_sx=639, out_sy=240, out_clip=1.
- Negative/truncation: x=-3, y=-3, z=2 -> issued dividends -768/2, qx=qy=-384 -> sx=-64 clamped to 0, sy=624 clamped to 479, out_clip=1.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD -> outputs stable, in_ready=0; with out_ready=1, in_ready=1 on the next cycle and a second vertex is processed correctly.
- Reset mid-WAIT: assert rst_n=0 for 1 cycle two cycles after ISSUE_X -> all outputs return to reset values; the stale quotient is not captured; the next vertex produces a correct result.

Source files
------------

// File: rtl/proj_pkg.sv
// Shared widths, state encoding and saturation helper for the perspective-divide sequencer.
package proj_pkg;

  localparam int unsigned COORD_W = 20;
  localparam int unsigned PROD_W  = 30;
  localparam int unsigned POS_W   = 21;
  localparam int unsigned SX_W    = 10;
  localparam int unsigned SY_W    = 9;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_X,
    ISSUE_Y,
    WAIT,
    HOLD
  } state_t;

  // Clamp a 30-bit signed product into the 20-bit signed divider operand range.
  function automatic logic signed [COORD_W-1:0] sat20(input logic signed [PROD_W-1:0] p);
    localparam logic signed [PROD_W-1:0] SAT_MAX = 30'sd524287;
    localparam logic signed [PROD_W-1:0] SAT_MIN = -30'sd524288;
    if (p > SAT_MAX) begin
      return {1'b0, {(COORD_W-1){1'b1}}};
    end else if (p < SAT_MIN) begin
      return {1'b1, {(COORD_W-1){1'b0}}};
    end else begin
      return COORD_W'(p);
    end
  endfunction

endpackage

// File: rtl/proj_sat_mul.sv
// Combinational signed coordinate x focal-length multiply, saturated to the divider operand width.
module proj_sat_mul
  import proj_pkg::*;
#(
  parameter int unsigned FOCAL = 256
) (
  input  logic signed [COORD_W-1:0] i_a,
  output logic signed [COORD_W-1:0] o_p_c
);

  localparam logic signed [10:0] FOCAL_S = $signed({1'b0, 10'(FOCAL)});

  logic signed [PROD_W:0] w_prod;

  // FOCAL is at most 512 in practice, so the 20x11 product always fits in 30 bits.
  assign w_prod = i_a * FOCAL_S;
  assign o_p_c  = sat20(PROD_W'(w_prod));

endmodule

// File: rtl/proj_div_seq.sv
// Perspective-divide sequencer: issues x*F/z and y*F/z to a pipelined divider and emits clamped screen coords.
module proj_div_seq
  import proj_pkg::*;
#(
  parameter int unsigned DIV_LAT = 24,
  parameter int unsigned FOCAL   = 256,
  parameter int unsigned SCR_W   = 640,
  parameter int unsigned SCR_H   = 480
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [COORD_W-1:0] in_x,
  input  logic signed [COORD_W-1:0] in_y,
  input  logic signed [COORD_W-1:0] in_z,
  output logic signed [COORD_W-1:0] div_dividend,
  output logic signed [COORD_W-1:0] div_divisor,
  input  logic signed [COORD_W-1:0] div_quotient,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic        [SX_W-1:0]    out_sx,
  output logic        [SY_W-1:0]    out_sy,
  output logic                      out_clip
);

  localparam int unsigned CNT_W = $clog2(DIV_LAT + 2);

  state_t                    r_state, w_state_nxt;
  logic [CNT_W-1:0]          r_lat, w_lat_nxt;
  logic signed [COORD_W-1:0] r_y, w_y_nxt;
  logic signed [COORD_W-1:0] r_z, w_z_nxt;
  logic signed [COORD_W-1:0] r_qx, w_qx_nxt;
  logic signed [COORD_W-1:0] r_dividend, w_dividend_nxt;
  logic signed [COORD_W-1:0] r_divisor, w_divisor_nxt;
  logic                      r_in_ready, w_in_ready_nxt;
  logic                      r_out_valid, w_out_valid_nxt;
  logic [SX_W-1:0]           r_sx, w_sx_nxt;
  logic [SY_W-1:0]           r_sy, w_sy_nxt;
  logic                      r_clip, w_clip_nxt;

  logic signed [COORD_W-1:0] w_mul_a, w_mul_p;
  logic signed [POS_W-1:0]   w_sx, w_sy;
  logic                      w_sx_lo, w_sx_hi, w_sy_lo, w_sy_hi;

  // One multiplier: x straight from the input at acceptance, latched y during ISSUE_X.
  assign w_mul_a = (r_state == IDLE) ? in_x : r_y;

  proj_sat_mul #(.FOCAL(FOCAL)) u_mul (
    .i_a   (w_mul_a),
    .o_p_c (w_mul_p)
  );

  // Screen mapping uses the captured qx and qy live on the divider output.
  assign w_sx    = POS_W'(SCR_W / 2) + {r_qx[COORD_W-1], r_qx};
  assign w_sy    = POS_W'(SCR_H / 2) - {div_quotient[COORD_W-1], div_quotient};
  assign w_sx_lo = w_sx[POS_W-1];
  assign w_sy_lo = w_sy[POS_W-1];
  assign w_sx_hi = !w_sx_lo && (w_sx >= POS_W'(SCR_W));
  assign w_sy_hi = !w_sy_lo && (w_sy >= POS_W'(SCR_H));

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_lat_nxt      = '0;
    w_y_nxt        = r_y;
    w_z_nxt        = r_z;
    w_qx_nxt       = r_qx;
    w_dividend_nxt = '0;
    w_divisor_nxt  = COORD_W'(1);
    w_sx_nxt       = r_sx;
    w_sy_nxt       = r_sy;
    w_clip_nxt     = r_clip;

    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_y_nxt = in_y;
          w_z_nxt = in_z;
          if (in_z <= 0) begin
            w_state_nxt = HOLD;
            w_clip_nxt  = 1'b1;
            w_sx_nxt    = '0;
            w_sy_nxt    = '0;
          end else begin
            w_state_nxt    = ISSUE_X;
            w_dividend_nxt = w_mul_p;
            w_divisor_nxt  = in_z;
          end
        end
      end
      ISSUE_X: begin
        w_state_nxt    = ISSUE_Y;
        w_lat_nxt      = CNT_W'(r_lat + 1'b1);
        w_dividend_nxt = w_mul_p;
        w_divisor_nxt  = r_z;
      end
      ISSUE_Y: begin
        w_state_nxt = WAIT;
        w_lat_nxt   = CNT_W'(r_lat + 1'b1);
      end
      WAIT: begin
        w_lat_nxt = CNT_W'(r_lat + 1'b1);
        if (r_lat == CNT_W'(DIV_LAT)) begin
          w_qx_nxt = div_quotient;
        end
        if (r_lat == CNT_W'(DIV_LAT + 1)) begin
          w_state_nxt = HOLD;
          w_lat_nxt   = '0;
          w_clip_nxt  = w_sx_lo || w_sx_hi || w_sy_lo || w_sy_hi;
          w_sx_nxt    = w_sx_lo ? '0 : (w_sx_hi ? SX_W'(SCR_W - 1) : w_sx[SX_W-1:0]);
          w_sy_nxt    = w_sy_lo ? '0 : (w_sy_hi ? SY_W'(SCR_H - 1) : w_sy[SY_W-1:0]);
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    w_in_ready_nxt  = (w_state_nxt == IDLE);
    w_out_valid_nxt = (w_state_nxt == HOLD);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_lat       <= '0;
      r_y         <= '0;
      r_z         <= '0;
      r_qx        <= '0;
      r_dividend  <= '0;
      r_divisor   <= COORD_W'(1);
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_sx        <= '0;
      r_sy        <= '0;
      r_clip      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lat       <= w_lat_nxt;
      r_y         <= w_y_nxt;
      r_z         <= w_z_nxt;
      r_qx        <= w_qx_nxt;
      r_dividend  <= w_dividend_nxt;
      r_divisor   <= w_divisor_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_sx        <= w_sx_nxt;
      r_sy        <= w_sy_nxt;
      r_clip      <= w_clip_nxt;
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_sx       = r_sx;
  assign out_sy       = r_sy;
  assign out_clip     = r_clip;
  assign div_dividend = r_dividend;
  assign div_divisor  = r_divisor;

endmodule

// File: tb/tb_proj_div_seq.sv
// Directed bench for proj_div_seq with a 4-cycle behavioural pipelined divider.
module tb_proj_div_seq;

  localparam int unsigned LAT = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [19:0] in_x, in_y, in_z;
  logic signed [19:0] div_dividend, div_divisor, div_quotient;
  logic               out_valid;
  logic               out_ready;
  logic        [9:0]  out_sx;
  logic        [8:0]  out_sy;
  logic               out_clip;

  int checks   = 0;
  int failures = 0;
  int zero_div = 0;

  always #5 clk = ~clk;

  proj_div_seq #(.DIV_LAT(LAT), .FOCAL(256), .SCR_W(640), .SCR_H(480)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_x         (in_x),
    .in_y         (in_y),
    .in_z         (in_z),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_quotient (div_quotient),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sx       (out_sx),
    .out_sy       (out_sy),
    .out_clip     (out_clip)
  );

  // Divider model: never reset, truncating division, LAT-cycle pipeline.
  logic signed [19:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= (div_divisor == 20'sd0) ? 20'sd0 : div_dividend / div_divisor;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign div_quotient = pipe[LAT-1];

  always @(negedge clk) if (div_divisor == 20'sd0) zero_div++;

  typedef struct {
    string name;
    int x, y, z;
    int dx, dy;
    int sx, sy, clip, lat;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Present a vertex and hold it until accepted; returns #1 after the accepting edge.
  task automatic accept(input vec_t v);
    int k;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 60) begin
      @(negedge clk);
      k++;
    end
    check({v.name, "_ready"}, int'(in_ready), 1);
    in_valid = 1'b1;
    in_x = 20'(v.x);
    in_y = 20'(v.y);
    in_z = 20'(v.z);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_x = 20'($urandom);
    in_y = 20'($urandom);
    in_z = 20'($urandom);
  endtask

  // Wait for out_valid, recording latency and the two issued dividends.
  task automatic wait_valid(output int lat, output int dx, output int dy, output bit seen);
    seen = 1'b0;
    lat = 0;
    dx = 0;
    dy = 0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) dx = int'(div_dividend);
      if (k == 2) dy = int'(div_dividend);
      if (out_valid) begin
        seen = 1'b1;
        lat = k;
      end
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int lat, dx, dy;
    bit seen;
    accept(v);
    wait_valid(lat, dx, dy, seen);
    check({v.name, "_valid_seen"}, int'(seen), 1);
    if (seen) begin
      check({v.name, "_lat"}, lat, v.lat);
      check({v.name, "_sx"}, int'(out_sx), v.sx);
      check({v.name, "_sy"}, int'(out_sy), v.sy);
      check({v.name, "_clip"}, int'(out_clip), v.clip);
      if (v.z > 0) begin
        check({v.name, "_dividend_x"}, dx, v.dx);
        check({v.name, "_dividend_y"}, dy, v.dy);
      end
      release_out();
    end
  endtask

  vec_t vecs [10];

  initial begin
    int lat, dx, dy, cnt;
    bit seen;

    vecs[0] = '{"nominal",    100,   50, 512,  25600,  12800, 370, 215, 0, 7};
    vecs[1] = '{"z_zero",      10,   20,   0,      0,      0,   0,   0, 1, 1};
    vecs[2] = '{"z_neg",       10,   10,  -5,      0,      0,   0,   0, 1, 1};
    vecs[3] = '{"sat_x",     4000,    0,   1, 524287,      0, 639, 240, 1, 7};
    vecs[4] = '{"neg_trunc",   -3,   -3,   2,   -768,   -768,   0, 479, 1, 7};
    vecs[5] = '{"trunc_mix", -100,  -80, 200, -25600, -20480, 192, 342, 0, 7};
    vecs[6] = '{"third",        1,    1,   3,    256,    256, 405, 155, 0, 7};
    vecs[7] = '{"edge_in",    319, -239, 256,  81664, -61184, 639, 479, 0, 7};
    vecs[8] = '{"sx_over",    320,    0, 256,  81920,      0, 639, 240, 1, 7};
    vecs[9] = '{"sy_under",  -320,  241, 256, -81920,  61696,   0,   0, 1, 7};

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_x = '0;
    in_y = '0;
    in_z = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_outputs", int'({out_sx, out_sy, out_clip}), 0);
    check("rst_dividend", int'(div_dividend), 0);
    check("rst_divisor", int'(div_divisor), 1);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Backpressure: outputs frozen while out_ready is low.
    accept(vecs[0]);
    wait_valid(lat, dx, dy, seen);
    check("bp_valid_seen", int'(seen), 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_stable", int'({out_valid, in_ready, out_clip, out_sx, out_sy}),
            int'({1'b1, 1'b0, 1'b0, 10'd370, 9'd215}));
    end
    release_out();
    @(negedge clk);
    check("bp_ready_after", int'({in_ready, out_valid}), 2);
    run_vec(vecs[6]);

    // Reset two cycles after ISSUE_X; stale quotients must be dropped.
    accept(vecs[0]);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_outputs", int'({out_sx, out_sy, out_clip}), 0);
    check("midrst_div_ops", int'({div_dividend, div_divisor}), 1);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("midrst_no_stale_valid", cnt, 0);
    run_vec(vecs[6]);

    check("divisor_never_zero", zero_div, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
